// File: rtl/aq_cpuio_sync_pkg.sv
// Shared definitions for the CPU-side IO boundary: FSM state encoding and
// the low-power "no request" code.
package aq_cpuio_sync_pkg;

  typedef enum logic [2:0] {
    ST_CFG   = 3'd0,
    ST_RUN   = 3'd1,
    ST_REQ   = 3'd2,
    ST_SLEEP = 3'd3,
    ST_WAKE  = 3'd4
  } state_t;

  localparam logic [1:0] LPMD_NONE = 2'b11;

endpackage

// File: rtl/aq_cpuio_int_sync.sv
// Multi-stage synchroniser for WIDTH asynchronous level signals; output is the
// last stage, so latency is STAGES clock cycles.
module aq_cpuio_int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Stage 0 occupies the low WIDTH bits; data shifts toward the top.
  logic [STAGES*WIDTH-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[(STAGES-1)*WIDTH-1:0], d};
    end
  end

  assign q = chain[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/aq_cpuio_sync_top.sv
// CPU-side IO boundary: interrupt synchronisation, CLINT time register, strap
// latch and the low-power request/ack handshake toward sysio.
module aq_cpuio_sync_top
  import aq_cpuio_sync_pkg::*;
#(
  parameter int INT_NUM   = 6,
  parameter int SYNC_STG  = 2,
  parameter int TIME_W    = 64,
  parameter int RVBA_W    = 40,
  parameter int COREID_W  = 3,
  parameter int TIME_MONO = 1
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic [COREID_W-1:0] pad_biu_coreid,
  input  logic [RVBA_W-1:0]   sysio_xx_rvba,
  input  logic [INT_NUM-1:0]  sysio_cpuio_int,
  input  logic [TIME_W-1:0]   clint_cpuio_time,
  input  logic                clint_cpuio_time_vld,
  input  logic [1:0]          cp0_biu_lpmd_b,
  input  logic                sysio_cpuio_lpmd_ack,
  output logic [COREID_W-1:0] biu_cp0_coreid,
  output logic [RVBA_W-1:0]   biu_cp0_rvba,
  output logic                biu_cp0_cfg_vld,
  output logic [INT_NUM-1:0]  biu_cp0_int,
  output logic [TIME_W-1:0]   biu_hpcp_time,
  output logic [1:0]          cpuio_sysio_lpmd_b,
  output logic                biu_cp0_lpmd_wakeup,
  output logic [2:0]          dbg_state
);

  // Handshake: lpmd_b != 11 is a request held until sysio acks (level); the
  // request is dropped back to 11 on interrupt, and sysio drops ack to finish.
  state_t state;
  logic   int_pend;

  aq_cpuio_int_sync #(
    .WIDTH  (INT_NUM),
    .STAGES (SYNC_STG)
  ) u_int_sync (
    .clk (forever_cpuclk),
    .rst (cpurst),
    .d   (sysio_cpuio_int),
    .q   (biu_cp0_int)
  );

  assign int_pend  = |biu_cp0_int;
  assign dbg_state = state;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      biu_hpcp_time <= '0;
    end else if (clint_cpuio_time_vld &&
                 ((TIME_MONO == 0) || (clint_cpuio_time >= biu_hpcp_time))) begin
      biu_hpcp_time <= clint_cpuio_time;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state               <= ST_CFG;
      biu_cp0_coreid      <= '0;
      biu_cp0_rvba        <= '0;
      biu_cp0_cfg_vld     <= 1'b0;
      cpuio_sysio_lpmd_b  <= LPMD_NONE;
      biu_cp0_lpmd_wakeup <= 1'b0;
    end else begin
      biu_cp0_lpmd_wakeup <= 1'b0;
      case (state)
        ST_CFG: begin
          biu_cp0_coreid  <= pad_biu_coreid;
          biu_cp0_rvba    <= sysio_xx_rvba;
          biu_cp0_cfg_vld <= 1'b1;
          state           <= ST_RUN;
        end
        ST_RUN: begin
          cpuio_sysio_lpmd_b <= LPMD_NONE;
          if ((cp0_biu_lpmd_b != LPMD_NONE) && !int_pend) begin
            cpuio_sysio_lpmd_b <= cp0_biu_lpmd_b;
            state              <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (int_pend) begin
            cpuio_sysio_lpmd_b <= LPMD_NONE;
            state              <= ST_WAKE;
          end else if (sysio_cpuio_lpmd_ack) begin
            state <= ST_SLEEP;
          end
        end
        ST_SLEEP: begin
          if (int_pend) begin
            cpuio_sysio_lpmd_b <= LPMD_NONE;
            state              <= ST_WAKE;
          end
        end
        ST_WAKE: begin
          cpuio_sysio_lpmd_b <= LPMD_NONE;
          if (!sysio_cpuio_lpmd_ack) begin
            biu_cp0_lpmd_wakeup <= 1'b1;
            state               <= ST_RUN;
          end
        end
        default: begin
          cpuio_sysio_lpmd_b <= LPMD_NONE;
          state              <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aq_cpuio_sync_top.sv
// Bench for aq_cpuio_sync_top: directed handshake/strap/reset steps followed by
// randomized interrupt and time traffic checked against a behavioural model.
module tb_aq_cpuio_sync_top;
  import aq_cpuio_sync_pkg::*;

  localparam int SYNC_STG = 2;

  logic        clk;
  logic        rst;
  logic [2:0]  coreid_in;
  logic [39:0] rvba_in;
  logic [5:0]  int_in;
  logic [63:0] time_in;
  logic        time_vld;
  logic [1:0]  lpmd_req;
  logic        ack;

  logic [2:0]  cp0_coreid, cp0_coreid_b;
  logic [39:0] cp0_rvba, cp0_rvba_b;
  logic        cfg_vld, cfg_vld_b;
  logic [5:0]  cp0_int, cp0_int_b;
  logic [63:0] hpcp_time, hpcp_time_b;
  logic [1:0]  lpmd_out, lpmd_out_b;
  logic        wakeup, wakeup_b;
  logic [2:0]  st, st_b;

  int tests = 0;
  int fails = 0;

  // Behavioural model: interrupt input history and the two time policies.
  logic [5:0]  int_hist_q[$];
  logic [5:0]  exp_int;
  logic [63:0] exp_t_mono;
  logic [63:0] exp_t_any;

  aq_cpuio_sync_top #(.TIME_MONO(1)) u_dut (
    .forever_cpuclk       (clk),
    .cpurst               (rst),
    .pad_biu_coreid       (coreid_in),
    .sysio_xx_rvba        (rvba_in),
    .sysio_cpuio_int      (int_in),
    .clint_cpuio_time     (time_in),
    .clint_cpuio_time_vld (time_vld),
    .cp0_biu_lpmd_b       (lpmd_req),
    .sysio_cpuio_lpmd_ack (ack),
    .biu_cp0_coreid       (cp0_coreid),
    .biu_cp0_rvba         (cp0_rvba),
    .biu_cp0_cfg_vld      (cfg_vld),
    .biu_cp0_int          (cp0_int),
    .biu_hpcp_time        (hpcp_time),
    .cpuio_sysio_lpmd_b   (lpmd_out),
    .biu_cp0_lpmd_wakeup  (wakeup),
    .dbg_state            (st)
  );

  aq_cpuio_sync_top #(.TIME_MONO(0)) u_dut_nomono (
    .forever_cpuclk       (clk),
    .cpurst               (rst),
    .pad_biu_coreid       (coreid_in),
    .sysio_xx_rvba        (rvba_in),
    .sysio_cpuio_int      (int_in),
    .clint_cpuio_time     (time_in),
    .clint_cpuio_time_vld (time_vld),
    .cp0_biu_lpmd_b       (lpmd_req),
    .sysio_cpuio_lpmd_ack (ack),
    .biu_cp0_coreid       (cp0_coreid_b),
    .biu_cp0_rvba         (cp0_rvba_b),
    .biu_cp0_cfg_vld      (cfg_vld_b),
    .biu_cp0_int          (cp0_int_b),
    .biu_hpcp_time        (hpcp_time_b),
    .cpuio_sysio_lpmd_b   (lpmd_out_b),
    .biu_cp0_lpmd_wakeup  (wakeup_b),
    .dbg_state            (st_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    int_hist_q = {};
    repeat (SYNC_STG - 1) int_hist_q.push_back(6'd0);
    exp_int    = 6'd0;
    exp_t_mono = 64'd0;
    exp_t_any  = 64'd0;
  endtask

  // One clock: sample pre-edge inputs, advance the model, return #1 after edge.
  task automatic tick();
    logic        s_rst = rst;
    logic [5:0]  s_int = int_in;
    logic        s_vld = time_vld;
    logic [63:0] s_t   = time_in;
    @(posedge clk);
    #1;
    if (s_rst) begin
      reset_model();
    end else begin
      int_hist_q.push_back(s_int);
      exp_int = int_hist_q.pop_front();
      if (s_vld) begin
        if (s_t >= exp_t_mono) exp_t_mono = s_t;
        exp_t_any = s_t;
      end
    end
  endtask

  task automatic load_time(input logic [63:0] t);
    time_in  = t;
    time_vld = 1'b1;
    tick();
    time_vld = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    coreid_in = 3'd5;
    rvba_in   = 40'h80_0000_0000;
    int_in    = '0;
    time_in   = '0;
    time_vld  = 1'b0;
    lpmd_req  = LPMD_NONE;
    ack       = 1'b0;
    reset_model();
    repeat (3) tick();

    chk("rst_cfg_vld", cfg_vld, 1'b0);
    chk("rst_lpmd", lpmd_out, 2'b11);
    chk("rst_state", st, ST_CFG);
    chk("rst_coreid", cp0_coreid, 3'd0);
    chk("rst_time", hpcp_time, 64'd0);
    chk("rst_wakeup", wakeup, 1'b0);

    rst = 1'b0;
    tick();
    chk("cfg_vld_c1", cfg_vld, 1'b1);
    chk("coreid_c1", cp0_coreid, 3'd5);
    chk("rvba_c1", cp0_rvba, 40'h80_0000_0000);
    chk("state_run", st, ST_RUN);

    coreid_in = 3'd2;
    rvba_in   = 40'h00_1234_5678;
    repeat (2) tick();
    chk("coreid_hold", cp0_coreid, 3'd5);
    chk("rvba_hold", cp0_rvba, 40'h80_0000_0000);

    // Interrupt latency of exactly SYNC_STG cycles.
    int_in = 6'b100000;
    tick();
    chk("int_lat1", cp0_int, 6'b000000);
    tick();
    chk("int_lat2", cp0_int, 6'b100000);
    int_in = '0;
    repeat (2) tick();
    chk("int_clear", cp0_int, 6'b000000);

    load_time(64'd100);
    chk("time_100_mono", hpcp_time, 64'd100);
    chk("time_100_any", hpcp_time_b, 64'd100);
    load_time(64'd50);
    chk("time_50_mono", hpcp_time, 64'd100);
    chk("time_50_any", hpcp_time_b, 64'd50);
    tick();
    chk("time_hold", hpcp_time, 64'd100);
    load_time('1);
    load_time(64'd0);
    chk("time_wrap_mono", hpcp_time, '1);
    chk("time_wrap_any", hpcp_time_b, 64'd0);

    // Full sleep / wakeup handshake.
    lpmd_req = 2'b00;
    tick();
    chk("req_lpmd", lpmd_out, 2'b00);
    chk("req_state", st, ST_REQ);
    ack = 1'b1;
    tick();
    chk("sleep_state", st, ST_SLEEP);
    lpmd_req = 2'b01;
    tick();
    chk("sleep_ignore_cp0", lpmd_out, 2'b00);
    int_in = 6'b100000;
    repeat (2) tick();
    chk("sleep_int_wait", lpmd_out, 2'b00);
    tick();
    chk("wake_lpmd", lpmd_out, 2'b11);
    chk("wake_state", st, ST_WAKE);
    int_in   = '0;
    lpmd_req = LPMD_NONE;
    tick();
    chk("wake_hold_ack", st, ST_WAKE);
    chk("wake_no_pulse", wakeup, 1'b0);
    ack = 1'b0;
    tick();
    chk("wakeup_pulse", wakeup, 1'b1);
    chk("back_run", st, ST_RUN);
    tick();
    chk("wakeup_1cyc", wakeup, 1'b0);

    // Request while an interrupt is pending stays in RUN.
    int_in = 6'b000100;
    repeat (2) tick();
    lpmd_req = 2'b10;
    tick();
    chk("run_int_block_st", st, ST_RUN);
    chk("run_int_block_lp", lpmd_out, 2'b11);
    int_in   = '0;
    lpmd_req = LPMD_NONE;
    repeat (3) tick();
    chk("int_drained", cp0_int, 6'b000000);

    // Interrupt and ack together in REQ: interrupt wins, no SLEEP.
    lpmd_req = 2'b01;
    tick();
    chk("req2_lpmd", lpmd_out, 2'b01);
    lpmd_req = LPMD_NONE;
    int_in   = 6'b100000;
    repeat (2) tick();
    chk("req2_still", st, ST_REQ);
    ack = 1'b1;
    tick();
    chk("req_int_ack_st", st, ST_WAKE);
    chk("req_int_ack_lp", lpmd_out, 2'b11);
    int_in = '0;
    ack    = 1'b0;
    tick();
    chk("req2_wakeup", wakeup, 1'b1);
    repeat (3) tick();

    // Async reset while in SLEEP.
    load_time(64'd777);
    lpmd_req = 2'b00;
    tick();
    ack = 1'b1;
    tick();
    chk("pre_rst_sleep", st, ST_SLEEP);
    rst = 1'b1;
    #1;
    reset_model();
    chk("arst_lpmd", lpmd_out, 2'b11);
    chk("arst_cfg_vld", cfg_vld, 1'b0);
    chk("arst_time", hpcp_time, 64'd0);
    chk("arst_state", st, ST_CFG);
    tick();
    rst      = 1'b0;
    ack      = 1'b0;
    lpmd_req = LPMD_NONE;
    tick();
    chk("rerel_cfg_vld", cfg_vld, 1'b1);
    chk("rerel_coreid", cp0_coreid, 3'd2);
    chk("rerel_rvba", cp0_rvba, 40'h00_1234_5678);

    // Randomized interrupt/time traffic with no low-power request.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) int_in = 6'($urandom);
      time_vld = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: time_in = exp_t_mono + 64'($urandom_range(0, 50));
        1: time_in = exp_t_mono - 64'($urandom_range(1, 50));
        2: time_in = {$urandom, $urandom};
        default: time_in = exp_t_mono;
      endcase
      tick();
      chk("rnd_int", cp0_int, exp_int);
      chk("rnd_time_mono", hpcp_time, exp_t_mono);
      chk("rnd_time_any", hpcp_time_b, exp_t_any);
      chk("rnd_lpmd", lpmd_out, 2'b11);
      chk("rnd_wakeup", wakeup, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
